// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   localparam int unsigned SA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage

// File: rtl/full_adder_by1.sv
// Combinational one-bit full-adder slice, reused every clock by the serial adder.
module full_adder_by1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum and majority carry of the three input bits
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder slice reused per clock.
// Optional macro SERIAL_ADD_OVERFLOW_EN adds the signed-overflow output ovf.
module serial_full_adder
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sa_state_t        r_state;
   sa_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum_sr;
   logic             r_carry;
   logic             r_cout;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s;
   logic             w_c;
   logic             w_accept;
   logic             w_release;
   logic             w_last;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic             r_ovf;
`endif

   assign w_accept  = in_valid & in_ready;
   assign w_release = out_valid & out_ready;
   assign w_last    = (r_cnt == CNT_LAST);

   full_adder_by1 u_slice (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (w_release) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Operand capture, serial add, sum shift and final carry/overflow capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_ADD_OVERFLOW_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
               r_carry  <= w_c;
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               if (w_last) begin
                  r_cout <= w_c;
`ifdef SERIAL_ADD_OVERFLOW_EN
                  // carry into MSB is the registered carry feeding this final slice
                  r_ovf  <= r_carry ^ w_c;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum_sr;
   assign cout = r_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
Bit-serial WIDTH-bit adder, the additive counterpart of the ripple full-subtractor datapath. One full-adder bit-slice is reused across WIDTH clocks, LSB first, with a registered carry. A valid/ready handshake on both sides lets it sit in area-constrained arithmetic paths that already use the ripple subtractor for the inverse operation.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  addend A.
b  input  WIDTH  addend B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
cout  output  1  carry-out of the MSB.

Behaviour:
- Reset: the clock is clk; reset is rst, synchronous and active-high. On reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, bit counter=0, carry reg=0, operand shift regs=0. Reset takes priority over all other events, including mid-RUN and during DONE; an in-flight operation is discarded without a result.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, capture a and b into shift regs, cin into the carry reg, clear counter, go to RUN.
- RUN: each cycle the bit-slice adds a_sr[0], b_sr[0] and carry. The sum bit shifts into sum_sr from the MSB side, the new carry is registered, a_sr and b_sr shift right, and the counter increments. When counter==WIDTH-1, the final slice result is registered and state goes to DONE. in_ready=0, and in_valid is ignored.
- DONE: out_valid=1. sum and cout hold stable until out_valid & out_ready, then state goes to IDLE. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: out_valid rises WIDTH clocks after the accepting edge. Max throughput is one result per WIDTH+2 cycles with out_ready tied high.
- sum and cout are driven from registers; no combinational path from inputs to outputs.
- Counter width is $clog2(WIDTH). The counter never wraps because it clears on acceptance.
- Inputs a, b and cin may change freely after acceptance without affecting the result.
- Edge cases:
  - All-ones + all-ones + cin=1 gives sum=all-ones, cout=1.
  - The carry chain propagates across all WIDTH bits.

Optional Feature:
SERIAL_ADD_OVERFLOW_EN:
- Defined: adds output port ovf (1 bit) = signed two's-complement overflow, computed as carry into MSB XOR carry out of MSB. It is registered with sum, valid with out_valid, and reset to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state typedef enum {IDLE, RUN, DONE};
  - default width constant SA_WIDTH_DEF=8.
- One sub-module, full_adder_by1 (a, b, cin -> s, cout), is the combinational bit-slice instantiated once. The top-level holds the FSM, counter and shift registers.

Test Plan:
- Plain add: a=0x3C, b=0x42, cin=0, out_ready=1 -> out_valid exactly 8 clocks after accept, sum=0x7E, cout=0; in_ready back to 1 one cycle later.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- Max with carry-in: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: a=0x10, b=0x20, out_ready held low 5 cycles in DONE -> sum=0x30 stable, out_valid=1 and in_ready=0 throughout; a second in_valid pulse is ignored; release out_ready -> IDLE.
- Reset mid-operation: assert rst at cycle 4 of RUN -> next edge IDLE, out_valid=0, sum=0, in_ready=1. A fresh op a=0x01, b=0x01 -> sum=0x02.
- Overflow (macro defined): a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. a=0x05, b=0xFB -> sum=0x00, cout=1, ovf=0.
